axis_lpf_mux_scheduler: RTL

- Time-multiplexed single-pole low-pass filter shared between N AXI-Stream input channels.
- A round-robin arbiter grants one channel at a time. A small FSM fetches that channel's filter state from a register bank, runs one shifted-alpha update and writes the state back.
- The result is emitted on a single AXI-Stream master tagged with the channel index.
- Sits between the sample-rate strobed ADC front ends and downstream logging/control, replacing N separate filter instances.

---
 rtl/axis_lpf_mux_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axis_lpf_mux_scheduler.sv
// Shared single-pole low-pass filter, time-multiplexed over n_channels AXI-Stream inputs.
// Define LPF_STATE_CLEAR_EN to add the per-channel i_clear state-reset port.
module axis_lpf_mux_scheduler #(
  parameter int n_channels             = 4,
  parameter int inout_width            = 12,
  parameter int inout_decimal_width    = 11,
  parameter int internal_width         = 32,
  parameter int internal_decimal_width = 31
) (
  input  logic                                aclk,
  input  logic                                reset,
  input  logic [5*n_channels-1:0]             i_alpha,
`ifdef LPF_STATE_CLEAR_EN
  input  logic [n_channels-1:0]               i_clear,
`endif
  input  logic [inout_width*n_channels-1:0]   s_axis_tdata,
  input  logic [n_channels-1:0]               s_axis_tvalid,
  output logic [n_channels-1:0]               s_axis_tready,
  output logic [inout_width-1:0]              m_axis_tdata,
  output logic [$clog2(n_channels)-1:0]       m_axis_tuser,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready
);

  localparam int user_w     = $clog2(n_channels);
  localparam int frac_shift = internal_decimal_width - inout_decimal_width;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEPT = 2'd1;
  localparam logic [1:0] CALC   = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  logic [1:0]                        r_state;
  logic [user_w-1:0]                 r_ptr;
  logic [user_w-1:0]                 r_grant;
  logic signed [inout_width-1:0]     r_x;
  logic signed [internal_width-1:0]  r_y;
  logic signed [internal_width-1:0]  r_bank [n_channels];
  logic [inout_width-1:0]            r_tdata;
  logic [user_w-1:0]                 r_tuser;
  logic                              r_tlast;
  logic                              r_tvalid;

  logic                              w_req_any;
  logic [user_w-1:0]                 w_req_idx;
  logic [4:0]                        w_alpha_raw;
  int                                w_shift;
  logic signed [internal_width-1:0]  w_x_sext;
  logic signed [internal_width-1:0]  w_x_ext;
  logic signed [internal_width:0]    w_d;
  logic signed [internal_width:0]    w_step;
  logic signed [internal_width-1:0]  w_y_new;

  function automatic logic [user_w-1:0] rr_index(input logic [user_w-1:0] base, input int offset);
    int idx;
    idx = int'(base) + offset;
    if (idx >= n_channels) idx = idx - n_channels;
    return user_w'(idx);
  endfunction

  // Scan from the far end so the lowest offset from the pointer wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_req_any = 1'b0;
    w_req_idx = '0;
    for (int i = n_channels - 1; i >= 0; i--) begin
      if (s_axis_tvalid[rr_index(r_ptr, i)]) begin
        w_req_any = 1'b1;
        w_req_idx = rr_index(r_ptr, i);
      end
    end
  end

  always_comb begin
    w_alpha_raw = i_alpha[5*int'(r_grant) +: 5];
    w_shift     = (int'(w_alpha_raw) > internal_width - 1) ? internal_width - 1 : int'(w_alpha_raw);
  end

  assign w_x_sext = {{(internal_width - inout_width){r_x[inout_width-1]}}, r_x};
  assign w_x_ext  = w_x_sext <<< frac_shift;
  assign w_d      = {w_x_ext[internal_width-1], w_x_ext} - {r_y[internal_width-1], r_y};
  assign w_step   = w_d >>> w_shift;
  // |y| < 1.0 guarantees the sum fits, so dropping the guard bit is exact.
  assign w_y_new  = r_y + internal_width'(w_step);

  always_comb begin
    s_axis_tready = '0;
    if (r_state == ACCEPT) s_axis_tready[r_grant] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req_any) begin
          r_grant <= w_req_idx;
          r_state <= ACCEPT;
        end
        ACCEPT: if (s_axis_tvalid[r_grant]) begin
          r_x     <= s_axis_tdata[inout_width*int'(r_grant) +: inout_width];
          r_y     <= r_bank[r_grant];
          r_state <= CALC;
        end else begin
          r_state <= IDLE;
        end
        CALC: begin
          r_ptr    <= (r_grant == user_w'(n_channels - 1)) ? '0 : r_grant + user_w'(1);
          r_tdata  <= w_y_new[frac_shift +: inout_width];
          r_tuser  <= r_grant;
          r_tlast  <= (r_grant == user_w'(n_channels - 1));
          r_tvalid <= 1'b1;
          r_state  <= OUTPUT;
        end
        OUTPUT: if (m_axis_tready) begin
          r_tvalid <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the state bank is small and must read as zero after reset, so it is reset explicitly.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < n_channels; k++) r_bank[k] <= '0;
    end else begin
      for (int k = 0; k < n_channels; k++) begin
        if (r_state == CALC && r_grant == user_w'(k)) r_bank[k] <= w_y_new;
`ifdef LPF_STATE_CLEAR_EN
        if (i_clear[k]) r_bank[k] <= '0;
`endif
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;

endmodule
